// File: rtl/nn_out_wb.sv
// nn_out_wb: pooled, requantised, saturated output write-back that streams packed bytes to DMA via a small FIFO
module nn_out_wb #(
    parameter int DATA_WIDTH     = 8,
    parameter int PSUM_WIDTH     = 19,
    parameter int LANE_NUM       = 2,
    parameter int DMA_DATA_WIDTH = 16,
    parameter int DMA_ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_cfg_relu,
    input  logic [1:0]                     i_cfg_pool,
    input  logic [3:0]                     i_cfg_shift,
    input  logic [DMA_ADDR_WIDTH-1:0]      i_cfg_base_addr,
    input  logic [11:0]                    i_cfg_count,
    input  logic                           i_valid,
    input  logic [LANE_NUM*PSUM_WIDTH-1:0] i_data,
    output logic                           o_ready,
    input  logic                           i_dma_wr_ready,
    output logic                           o_dma_wr_en,
    output logic [DMA_ADDR_WIDTH-1:0]      o_dma_wr_addr,
    output logic [DMA_DATA_WIDTH-1:0]      o_dma_wr_data,
    output logic                           o_busy,
    output logic                           o_done
);
    localparam int WPB = LANE_NUM * DATA_WIDTH / DMA_DATA_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CX  = CW + 1;
    localparam int BW  = LANE_NUM * DATA_WIDTH;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic signed [PSUM_WIDTH-1:0] SAT_HI = PSUM_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [PSUM_WIDTH-1:0] SAT_LO = PSUM_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    logic [1:0]                     state_q, state_d;
    logic                           cfg_relu_q;
    logic [1:0]                     cfg_pool_q;
    logic [3:0]                     cfg_shift_q;
    logic [11:0]                    cfg_count_q;
    logic [1:0]                     pool_cnt_q;
    logic [12:0]                    beats_q;
    logic [11:0]                    words_q;
    logic [DMA_ADDR_WIDTH-1:0]      addr_q;
    logic signed [PSUM_WIDTH-1:0]   max_q [LANE_NUM];
    logic signed [PSUM_WIDTH-1:0]   in_w  [LANE_NUM];
    logic signed [PSUM_WIDTH-1:0]   cur_d [LANE_NUM];
    logic signed [PSUM_WIDTH-1:0]   sh_w  [LANE_NUM];
    logic                           s1_v_q;
    logic [BW-1:0]                  s1_q, s1_d;
    logic [DMA_DATA_WIDTH-1:0]      mem_data [FIFO_DEPTH];
    logic [DMA_ADDR_WIDTH-1:0]      mem_addr [FIFO_DEPTH];
    logic [AW-1:0]                  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                  cnt_q;
    logic                           start_ok, accept, close, pop;
    logic [11:0]                    rem;
    logic [CW-1:0]                  n_push;
    logic [12:0]                    beats_lim;
    logic [CX-1:0]                  free_w, need_w;

    // Per-lane running max including the current beat, then shift, saturate and optional ReLU.
    always_comb begin
        s1_d = '0;
        for (int k = 0; k < LANE_NUM; k++) begin
            in_w[k]  = i_data[k*PSUM_WIDTH +: PSUM_WIDTH];
            cur_d[k] = (pool_cnt_q == 2'd0 || in_w[k] > max_q[k]) ? in_w[k] : max_q[k];
            sh_w[k]  = cur_d[k] >>> cfg_shift_q;
            s1_d[k*DATA_WIDTH +: DATA_WIDTH] = (cfg_relu_q && sh_w[k][PSUM_WIDTH-1]) ? '0 :
                                               sh_w[k] > SAT_HI ? SAT_HI[DATA_WIDTH-1:0] :
                                               sh_w[k] < SAT_LO ? SAT_LO[DATA_WIDTH-1:0] :
                                               sh_w[k][DATA_WIDTH-1:0];
        end
    end

    // Handshake, FIFO room, push sizing and next state.
    always_comb begin
        start_ok  = (state_q == S_IDLE) && i_start;
        beats_lim = ({1'b0, cfg_count_q} + 13'(WPB - 1)) / 13'(WPB);
        free_w    = CX'(FIFO_DEPTH) - {1'b0, cnt_q};
        need_w    = s1_v_q ? CX'(2 * WPB) : CX'(WPB);
        o_ready   = (state_q == S_RUN) && (free_w >= need_w) && (beats_q < beats_lim);
        accept    = i_valid && o_ready;
        close     = accept && (pool_cnt_q == cfg_pool_q);
        rem       = cfg_count_q - words_q;
        n_push    = !s1_v_q ? '0 : (rem < 12'(WPB)) ? CW'(rem) : CW'(WPB);
        pop       = (cnt_q != '0) && i_dma_wr_ready;
        state_d   = (state_q == S_IDLE)  ? (i_start ? S_RUN : S_IDLE) :
                    (state_q == S_RUN)   ? ((words_q == cfg_count_q) ? S_DRAIN : S_RUN) :
                    (state_q == S_DRAIN) ? ((cnt_q == '0) ? S_DONE : S_DRAIN) :
                    S_IDLE;
    end

    assign o_dma_wr_en   = cnt_q != '0;
    assign o_dma_wr_addr = o_dma_wr_en ? mem_addr[rd_ptr_q] : '0;
    assign o_dma_wr_data = o_dma_wr_en ? mem_data[rd_ptr_q] : '0;
    assign o_busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign o_done        = state_q == S_DONE;

    // Control state, pooling window, stage-1 register and FIFO pointers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            cfg_relu_q  <= 1'b0;
            cfg_pool_q  <= '0;
            cfg_shift_q <= '0;
            cfg_count_q <= '0;
            pool_cnt_q  <= '0;
            beats_q     <= '0;
            words_q     <= '0;
            addr_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            for (int k = 0; k < LANE_NUM; k++) max_q[k] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_q + AW'(n_push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            cnt_q    <= cnt_q + n_push - CW'(pop);
            s1_v_q   <= close;
            if (close) s1_q <= s1_d;
            if (start_ok) begin
                cfg_relu_q  <= i_cfg_relu;
                cfg_pool_q  <= i_cfg_pool;
                cfg_shift_q <= i_cfg_shift;
                cfg_count_q <= i_cfg_count;
                pool_cnt_q  <= '0;
                beats_q     <= '0;
                words_q     <= '0;
                addr_q      <= i_cfg_base_addr;
            end else begin
                words_q <= words_q + 12'(n_push);
                addr_q  <= addr_q + DMA_ADDR_WIDTH'(n_push);
                if (accept) begin
                    pool_cnt_q <= close ? 2'd0 : pool_cnt_q + 2'd1;
                    beats_q    <= beats_q + 13'(close);
                    for (int k = 0; k < LANE_NUM; k++) max_q[k] <= cur_d[k];
                end
            end
        end
    end

    // FIFO storage: pack stage-1 bytes into words, each carrying its DMA address.
    always_ff @(posedge i_clk) begin
        for (int w = 0; w < WPB; w++) begin
            if (CW'(w) < n_push) begin
                mem_data[wr_ptr_q + AW'(w)] <= s1_q[w*DMA_DATA_WIDTH +: DMA_DATA_WIDTH];
                mem_addr[wr_ptr_q + AW'(w)] <= addr_q + DMA_ADDR_WIDTH'(w);
            end
        end
    end
endmodule

// File: tb/tb_nn_out_wb.sv
// tb_nn_out_wb: randomized and directed jobs checked against a window/max/shift/saturate reference model
module tb_nn_out_wb;
    logic        i_clk = 0, i_rst = 0, i_start = 0, i_cfg_relu = 0;
    logic [1:0]  i_cfg_pool = 0;
    logic [3:0]  i_cfg_shift = 0;
    logic [4:0]  i_cfg_base_addr = 0;
    logic [11:0] i_cfg_count = 0;
    logic        i_valid = 0;
    logic [37:0] i_data = 0;
    logic        o_ready;
    logic        i_dma_wr_ready = 0;
    logic        o_dma_wr_en;
    logic [4:0]  o_dma_wr_addr;
    logic [15:0] o_dma_wr_data;
    logic        o_busy, o_done;

    int checks = 0, errors = 0;
    int acc_at_hold, done_cycle;
    logic [37:0] beats_in[$];
    logic [20:0] exp_q[$], got_q[$];

    nn_out_wb dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cfg_relu(i_cfg_relu),
        .i_cfg_pool(i_cfg_pool), .i_cfg_shift(i_cfg_shift), .i_cfg_base_addr(i_cfg_base_addr),
        .i_cfg_count(i_cfg_count), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .i_dma_wr_ready(i_dma_wr_ready), .o_dma_wr_en(o_dma_wr_en), .o_dma_wr_addr(o_dma_wr_addr),
        .o_dma_wr_data(o_dma_wr_data), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [37:0] mk(input int a, input int b);
        return {19'(b), 19'(a)};
    endfunction

    function automatic int rnd_psum();
        int v;
        logic signed [18:0] r;
        if ($urandom_range(1) == 0) begin
            v = $urandom_range(600);
            return v - 300;
        end
        r = 19'($urandom);
        return int'(r);
    endfunction

    // Expected DMA writes: max over each window of P beats, shift, clamp to a signed byte, ReLU.
    task automatic model(input bit relu, input int p, input int shift, input int base, input int count);
        logic [15:0] word;
        logic [37:0] b;
        logic signed [18:0] t;
        int m, v;
        exp_q.delete();
        for (int w = 0; w < count; w++) begin
            word = 0;
            for (int k = 0; k < 2; k++) begin
                m = -(1 << 30);
                for (int j = 0; j < p; j++) begin
                    b = beats_in[w*p+j];
                    t = b[k*19 +: 19];
                    if (int'(t) > m) m = int'(t);
                end
                v = m >>> shift;
                if (v > 127) v = 127;
                if (v < -128) v = -128;
                if (relu && v < 0) v = 0;
                word[k*8 +: 8] = 8'(v);
            end
            exp_q.push_back({5'((base + w) % 32), word});
        end
    endtask

    task automatic run_job(input string name, input bit relu, input int pool, input int shift,
                           input int base, input int count, input int hold, input int vprob, input int rprob);
        int n, idx;
        bit stall;
        logic [20:0] prev;
        n = count * (pool + 1);
        model(relu, pool + 1, shift, base, count);
        got_q.delete();
        idx = 0; stall = 0; prev = 0; acc_at_hold = -1; done_cycle = -1;
        i_start = 1; i_cfg_relu = relu; i_cfg_pool = 2'(pool); i_cfg_shift = 4'(shift);
        i_cfg_base_addr = 5'(base); i_cfg_count = 12'(count);
        @(posedge i_clk); #1;
        i_start = 0; i_cfg_relu = 1'($urandom); i_cfg_pool = 2'($urandom); i_cfg_shift = 4'($urandom);
        i_cfg_base_addr = 5'($urandom); i_cfg_count = 12'($urandom);
        for (int c = 1; c <= 3000 && done_cycle < 0; c++) begin
            i_valid = (idx < n) ? ($urandom_range(99) < vprob) : ($urandom_range(1) == 1);
            i_data = (idx < n) ? beats_in[idx] : 38'($urandom);
            i_dma_wr_ready = (c <= hold) ? 1'b0 : ($urandom_range(99) < rprob);
            if (stall) begin
                checks++;
                if ({o_dma_wr_en, o_dma_wr_addr, o_dma_wr_data} !== {1'b1, prev}) begin
                    errors++;
                    $display("FAIL %s hold: got en=%0b word=%h required en=1 word=%h", name, o_dma_wr_en, {o_dma_wr_addr, o_dma_wr_data}, prev);
                end
            end
            if (idx >= n && i_valid) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s extra_beat: o_ready=%0b required 0", name, o_ready);
                end
            end
            if (i_valid && o_ready && idx < n) idx++;
            if (o_dma_wr_en && i_dma_wr_ready) got_q.push_back({o_dma_wr_addr, o_dma_wr_data});
            stall = o_dma_wr_en && !i_dma_wr_ready;
            prev = {o_dma_wr_addr, o_dma_wr_data};
            if (c == hold) acc_at_hold = idx;
            if (o_done) done_cycle = c;
            @(posedge i_clk); #1;
        end
        i_valid = 0; i_dma_wr_ready = 0;
        checks++;
        if (done_cycle < 0) begin
            errors++;
            $display("FAIL %s timeout: o_done never seen, required within 3000 cycles", name);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({o_done, o_busy, o_dma_wr_en} !== 3'b000) begin
                errors++;
                $display("FAIL %s after_done: done/busy/en=%b required 000", name, {o_done, o_busy, o_dma_wr_en});
            end
            @(posedge i_clk); #1;
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s word_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s word%0d: got addr=%0d data=%h required addr=%0d data=%h", name, i, got_q[i][20:16], got_q[i][15:0], exp_q[i][20:16], exp_q[i][15:0]);
            end
        end
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s beats_accepted: got %0d required %0d", name, idx, n);
        end
    endtask

    task automatic test_reset();
        i_rst = 0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if ({o_ready, o_dma_wr_en, o_dma_wr_addr, o_dma_wr_data, o_busy, o_done} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", {o_ready, o_dma_wr_en, o_dma_wr_addr, o_dma_wr_data, o_busy, o_done});
        end
        i_rst = 1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_busy, o_done, o_ready} !== 3'b000) begin
            errors++;
            $display("FAIL idle_after_reset: busy/done/ready=%b required 000", {o_busy, o_done, o_ready});
        end
    endtask

    task automatic test_basic();
        beats_in = '{mk(5, -3), mk(127, 200)};
        run_job("basic", 0, 0, 0, 3, 2, 0, 100, 100);
        checks++;
        if (got_q.size() < 2 || got_q[0] !== {5'd3, 16'hFD05} || got_q[1] !== {5'd4, 16'h7F7F}) begin
            errors++;
            $display("FAIL basic_const: got %0d words, first %h required 03/FD05 then 04/7F7F", got_q.size(), got_q.size() > 0 ? got_q[0] : 21'd0);
        end
    endtask

    task automatic test_relu_sat();
        beats_in = '{mk(-7, 9)};
        run_job("relu", 1, 0, 0, 0, 1, 0, 100, 100);
        checks++;
        if (got_q.size() != 1 || got_q[0][15:0] !== 16'h0900) begin
            errors++;
            $display("FAIL relu_const: got %h required 0900", got_q.size() > 0 ? got_q[0][15:0] : 16'hxxxx);
        end
        beats_in = '{mk(-200, 0)};
        run_job("sat", 0, 0, 0, 0, 1, 0, 100, 100);
        checks++;
        if (got_q.size() != 1 || got_q[0][15:0] !== 16'h0080) begin
            errors++;
            $display("FAIL sat_const: got %h required 0080", got_q.size() > 0 ? got_q[0][15:0] : 16'hxxxx);
        end
    endtask

    task automatic test_pool();
        beats_in = '{mk(1, 10), mk(8, -5), mk(-2, 20), mk(3, 7)};
        run_job("pool4", 0, 3, 1, 9, 1, 0, 100, 100);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {5'd9, 16'h0A04}) begin
            errors++;
            $display("FAIL pool_const: got %h required 09/0A04", got_q.size() > 0 ? got_q[0] : 21'd0);
        end
        beats_in.delete();
        for (int i = 0; i < 12; i++) beats_in.push_back(mk(rnd_psum(), rnd_psum()));
        run_job("pool3", 1, 2, 2, 0, 4, 0, 70, 80);
    endtask

    task automatic test_backpressure();
        beats_in.delete();
        for (int i = 0; i < 10; i++) beats_in.push_back(mk(rnd_psum(), rnd_psum()));
        run_job("backpressure", 0, 0, 0, 12, 10, 20, 100, 100);
        checks++;
        if (acc_at_hold != 8) begin
            errors++;
            $display("FAIL backpressure_fill: beats accepted while stalled %0d required 8", acc_at_hold);
        end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{30, 31, 0, 1};
        beats_in.delete();
        for (int i = 0; i < 4; i++) beats_in.push_back(mk(rnd_psum(), rnd_psum()));
        run_job("wrap", 0, 0, 3, 30, 4, 0, 100, 60);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_q.size() != 4 || int'(got_q[i][20:16]) != exp_a[i]) begin
                errors++;
                $display("FAIL wrap_addr%0d: got %0d required %0d", i, got_q.size() > i ? int'(got_q[i][20:16]) : -1, exp_a[i]);
            end
        end
        beats_in.delete();
        run_job("count0", 0, 0, 0, 7, 0, 0, 100, 100);
        checks++;
        if (done_cycle != 3) begin
            errors++;
            $display("FAIL count0_done: o_done at cycle %0d required 3", done_cycle);
        end
    endtask

    task automatic test_reset_mid();
        beats_in.delete();
        for (int i = 0; i < 8; i++) beats_in.push_back(mk(rnd_psum(), rnd_psum()));
        i_start = 1; i_cfg_relu = 0; i_cfg_pool = 0; i_cfg_shift = 0; i_cfg_base_addr = 5; i_cfg_count = 8;
        @(posedge i_clk); #1;
        i_start = 0; i_dma_wr_ready = 0;
        for (int i = 0; i < 6; i++) begin
            i_valid = 1; i_data = beats_in[i];
            @(posedge i_clk); #1;
        end
        checks++;
        if (o_dma_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: o_dma_wr_en=%0b required 1", o_dma_wr_en);
        end
        i_rst = 0; i_dma_wr_ready = 1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_ready, o_dma_wr_en, o_dma_wr_addr, o_dma_wr_data, o_busy, o_done} !== 25'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h required 0", {o_ready, o_dma_wr_en, o_dma_wr_addr, o_dma_wr_data, o_busy, o_done});
        end
        i_rst = 1; i_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clk); #1;
            checks++;
            if ({o_dma_wr_en, o_done, o_busy} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_quiet: en/done/busy=%b required 000", {o_dma_wr_en, o_done, o_busy});
            end
        end
        run_job("after_reset", 0, 0, 0, 5, 8, 0, 90, 90);
    endtask

    task automatic test_random();
        int pool, count;
        for (int j = 0; j < 8; j++) begin
            pool = $urandom_range(3);
            count = $urandom_range(12, 1);
            beats_in.delete();
            for (int i = 0; i < count * (pool + 1); i++) beats_in.push_back(mk(rnd_psum(), rnd_psum()));
            run_job("random", 1'($urandom), pool, ($urandom_range(1) == 1) ? $urandom_range(4) : $urandom_range(15),
                    $urandom_range(31), count, 0, $urandom_range(100, 40), $urandom_range(100, 30));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu_sat();
        test_pool();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
